// File: rtl/risc_pkg.sv
// Shared definitions for the data-memory arbiter.
//   DEF_DATA_W / DEF_ADDR_W : default word and address widths
//   owner_t                 : which requester last owned the memory
//   state_t                 : arbiter FSM states
package risc_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 16;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  typedef enum logic {
    IDLE       = 1'b0,
    HOST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant with a priority override for requester b.
//   req_a, req_b   : requests
//   last_b         : 1 when b owned the last granted cycle (a wins a tie)
//   force_b        : b wins whenever it requests; a only gets idle cycles
//   gnt_a, gnt_b   : one-hot-or-zero grants (combinational)
module rr_grant2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last_b,
  input  logic force_b,
  output logic gnt_a,
  output logic gnt_b
);

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (force_b && req_b) begin
      gnt_b = 1'b1;
    end else if (req_a && req_b) begin
      // Tie: the port that did not own the last cycle wins.
      if (last_b) gnt_a = 1'b1;
      else        gnt_b = 1'b1;
    end else if (req_a) begin
      gnt_a = 1'b1;
    end else if (req_b) begin
      gnt_b = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU load/store path
// and the host/DMA port. Host may hold the memory for up to MAX_BURST
// consecutive grants while host_lock is held.
//   clk, rst                       : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          : CPU access request
//   cpu_gnt, cpu_stall             : CPU grant / stall (combinational)
//   cpu_rvalid, cpu_rdata          : CPU load return (registered)
//   host_req/we/lock/addr/wdata    : host access request
//   host_gnt                       : host grant (combinational)
//   host_rvalid, host_rdata        : host read return (registered)
//   mem_addr/wdata/we/re           : memory drive (combinational)
//   mem_rdata                      : memory combinational read data
module dmem_arbiter
  import risc_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W    = 4;
  // With a one-grant limit a burst would end as soon as it started.
  localparam bit          BURST_EN = (MAX_BURST > 1);

  state_t           state, state_nxt;
  owner_t           last_owner, last_owner_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

  // Grant selection
  rr_grant2 u_grant (
    .req_a   (cpu_req),
    .req_b   (host_req),
    .last_b  (last_owner == OWN_HOST),
    .force_b (state == HOST_BURST),
    .gnt_a   (cpu_gnt),
    .gnt_b   (host_gnt)
  );

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Memory drive from the granted port; all zero when nobody is granted
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = ~cpu_we;
    end else if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we;
      mem_re    = ~host_we;
    end
  end

  // FSM, owner and burst counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= OWN_HOST;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    burst_cnt_nxt  = burst_cnt;

    if (cpu_gnt)       last_owner_nxt = OWN_CPU;
    else if (host_gnt) last_owner_nxt = OWN_HOST;

    case (state)
      IDLE: begin
        if (host_gnt && host_lock && BURST_EN) begin
          state_nxt     = HOST_BURST;
          burst_cnt_nxt = CNT_W'(1);
        end
      end
      HOST_BURST: begin
        if (host_gnt) burst_cnt_nxt = burst_cnt + CNT_W'(1);
        // Exit on the limit leaves last_owner=HOST, so a waiting CPU wins next.
        if (!host_lock || !host_req || (burst_cnt_nxt == CNT_W'(MAX_BURST))) begin
          state_nxt     = IDLE;
          burst_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  // Read return: capture data on a granted read, rvalid pulses one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid  <= 1'b0;
      cpu_rdata   <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      cpu_rvalid  <= cpu_gnt & ~cpu_we;
      host_rvalid <= host_gnt & ~host_we;
      if (cpu_gnt && !cpu_we)   cpu_rdata  <= mem_rdata;
      if (host_gnt && !host_we) host_rdata <= mem_rdata;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single-port 16-bit data memory between the CPU datapath (load/store path) and a host/DMA port used for loading and inspecting data RAM.
- Grants at most one requester per cycle and drives the memory's address, write-data, write-enable and read-enable.
- Returns registered read data to the owning requester.
- Produces a CPU stall whenever the CPU loses arbitration.
- Sits between the datapath's memory access signals and the data memory.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, access address width (forwarded unmodified; memory decodes low bits)
MAX_BURST, 4, maximum consecutive host grants while host_lock held (range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
cpu_req  in  1  CPU access request (load or store)
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU store data
cpu_gnt  out  1  CPU access performed this cycle (combinational)
cpu_stall  out  1  cpu_req & ~cpu_gnt
cpu_rvalid  out  1  CPU load data valid (registered, one cycle after grant)
cpu_rdata  out  DATA_W  CPU load data
host_req  in  1  host access request
host_we  in  1  1=write, 0=read
host_lock  in  1  host requests burst ownership
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  host access performed this cycle (combinational)
host_rvalid  out  1  host read data valid (registered)
host_rdata  out  DATA_W  host read data
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write enable
mem_re  out  1  memory read enable
mem_rdata  in  DATA_W  memory combinational read data

Behaviour:
Reset:
- rst sampled on rising clk only.
- Reset state: state=IDLE, last_owner=HOST (CPU wins the first contention), burst_cnt=0.
- cpu_rvalid=host_rvalid=0, cpu_rdata=host_rdata=0.
- Combinational outputs follow from the reset state: gnt=0 when no req; mem_we=mem_re=0 with no grant; mem_addr/mem_wdata=0 when idle.

Grant (combinational from state and reqs):
- IDLE, single requester: that requester is granted.
- IDLE, both requesting: grant goes to the port not equal to last_owner.
- HOST_BURST: host is granted if host_req. CPU is granted only if host_req=0.
- Exactly one grant or none per cycle; never both.

Memory drive:
- mem_addr, mem_wdata and mem_we come from the granted port (mem_we = gnt & we).
- mem_re = gnt & ~we.
- No grant: all memory outputs 0.

Read return:
- On a rising edge with a granted read, capture mem_rdata into that port's rdata and pulse its rvalid for exactly one cycle.
- rdata holds its value until the next read for that port.
- Writes never pulse rvalid.

last_owner:
- Updated to the granted port on every granted cycle.
- Unchanged on idle cycles.

FSM, IDLE -> HOST_BURST:
- Taken when host is granted with host_lock=1.
- burst_cnt loads 1.

FSM, HOST_BURST:
- Each host grant increments burst_cnt.
- Exit to IDLE when any of the following holds:
  - host_lock=0 at a clock edge;
  - host_req=0 at a clock edge;
  - burst_cnt==MAX_BURST after the grant.
- On exit by MAX_BURST, last_owner=HOST, so a pending cpu_req wins the next cycle (no CPU starvation).
- Maximum CPU stall = MAX_BURST cycles.

Simultaneous events:
- Host asserts lock in the same cycle it loses contention: no burst starts.
- Burst entry requires an actual host grant.

Reset mid-operation:
- Aborts a burst.
- Discards a pending rvalid (rvalid=0 the next cycle).
- A write granted in the reset cycle still reaches memory (combinational); the reset-cycle write occurs.

Decomposition:
- Shared package (risc_pkg): DATA_W/ADDR_W defaults; owner encoding (OWN_CPU=1'b0, OWN_HOST=1'b1); state encoding (IDLE=1'b0, HOST_BURST=1'b1).
- Natural sub-module: rr_grant2, a two-way round-robin grant function with priority override, instantiated once.
- Read-return registers and FSM remain in the top module.

Test Plan:
- CPU load only: rst 1 cycle; cpu_req=1, we=0, addr=0x0003, mem_rdata=0x1234 -> cpu_gnt=1, mem_re=1, mem_addr=0x0003 same cycle; next cycle cpu_rvalid=1, cpu_rdata=0x1234; cpu_stall=0 throughout.
- Contention after reset: cpu and host both request reads -> cycle 1 cpu_gnt, host_gnt=0; cycle 2 host_gnt; alternates every cycle while both held.
- Host burst: host_lock=1, host writes 0x00AA..0x00AD to addr 0..3 with cpu_req held -> host granted 4 consecutive cycles with cpu_stall=1; cycle 5 cpu_gnt=1; cpu_stall never high more than 4 consecutive cycles.
- Lock drop: host_lock deasserted after 2 burst grants -> FSM returns to IDLE; next contention grants CPU (last_owner=HOST).
- Store path: cpu_req=1, we=1, addr=0x0005, wdata=0xBEEF -> mem_we=1, mem_wdata=0xBEEF, no cpu_rvalid next cycle.
- Reset mid-burst: rst asserted during the 2nd burst grant -> next cycle state IDLE, rvalids 0, rdata 0, and the first contention grants CPU.
